// File: rtl/iram_write_pkg.sv
// Shared types and constants for the IRAM write path: sequencer state,
// word widths and the A-bus field that supplies the upper instruction bits.
package iram_write_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2,
    ST_HOLD  = 2'd3
  } iram_wr_state_e;

  localparam int IRAM_DATA_W = 48;
  localparam int IRAM_WORD_W = 49;

  // A bus bits that land in word bits 47:32
  localparam int A_HI_MSB = 15;
  localparam int A_HI_LSB = 0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/iram_parity_gen.sv
// Odd-parity generator over one IRAM data word: the returned bit makes the
// data-plus-parity word carry an odd number of ones. Shared with read-side checking.
module iram_parity_gen
  import iram_write_pkg::*;
(
  input  logic [IRAM_DATA_W-1:0] data,
  output logic                   par_odd
);

  assign par_odd = ~^data;

endmodule

// File: rtl/iram_write_seq.sv
// IRAM write sequencer: latches a microinstruction from the A/M buses, adds
// parity, and drives address/data/we with programmable setup, pulse and hold.
module iram_write_seq
  import iram_write_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int SETUP_CYC = 1,
  parameter int WE_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            a_data,
  input  logic [31:0]            m_data,
  input  logic [ADDR_W-1:0]      wadr,
  output logic [ADDR_W-1:0]      iram_addr,
  output logic [IRAM_WORD_W-1:0] iram_wdata,
  output logic                   iram_we,
  output logic                   busy,
  output logic                   done
);

  localparam int MAX_CYC = max3(SETUP_CYC, WE_CYC, HOLD_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] WE_LD    = CNT_W'(WE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  iram_wr_state_e          state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [IRAM_WORD_W-1:0]  wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [IRAM_DATA_W-1:0]  cap_data;
  logic                    cap_par;
  logic                    accept;
  logic                    cnt_zero;

  // A bus upper half carries nothing for this path
  logic unused_a_hi;
  assign unused_a_hi = ^a_data[31:A_HI_MSB+1];

  assign cap_data = {a_data[A_HI_MSB:A_HI_LSB], m_data};
  assign accept   = (state_q == ST_IDLE) && start;
  assign cnt_zero = (cnt_q == '0);

  iram_parity_gen u_par (
    .data    (cap_data),
    .par_odd (cap_par)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)    state_d = ST_SETUP;
      ST_SETUP: if (cnt_zero) state_d = ST_WRITE;
      ST_WRITE: if (cnt_zero) state_d = ST_HOLD;
      ST_HOLD:  if (cnt_zero) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_d != state_q) begin
      case (state_d)
        ST_SETUP: cnt_d = SETUP_LD;
        ST_WRITE: cnt_d = WE_LD;
        ST_HOLD:  cnt_d = HOLD_LD;
        default:  cnt_d = '0;
      endcase
    end else if (!cnt_zero) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (accept) begin
      addr_d  = wadr;
      wdata_d = {cap_par, cap_data};
    end
    we_d   = (state_d == ST_WRITE);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_HOLD) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign iram_addr  = addr_q;
  assign iram_wdata = wdata_q;
  assign iram_we    = we_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
